id_ex_alu_stage: RTL and testbench
==================================

Name: id_ex_alu_stage

Overview:
- ID/EX pipeline register for the 5-stage 32-bit MIPS pipeline, placed directly upstream of the 32-bit ripple ALU built from the 1-bit slices.
- Latches the decoded instruction fields and produces the ALU's 3-bit `ctl` code.
- Selects the forwarded A/B operands from EX/MEM and MEM/WB.
- Detects load-use hazards so that ID can stall.

Parameters:
- WIDTH, 32, datapath width.
- REGW, 5, register-specifier width.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold the ID/EX register (external stall)
- flush  in  1  load a bubble into ID/EX (branch taken)
- id_opcode  in  6  instruction[31:26]
- id_funct  in  6  instruction[5:0]
- id_rs, id_rt, id_rd  in  REGW each  register specifiers
- id_rs_data, id_rt_data  in  WIDTH each  register file read data
- id_imm  in  WIDTH  immediate, already extended by ID
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_dst, id_alu_src  in  1 each  control bits
- exmem_reg_write  in  1  write enable of the EX/MEM instruction
- exmem_rd  in  REGW  destination of the EX/MEM instruction
- exmem_result  in  WIDTH  ALU result in EX/MEM
- memwb_reg_write  in  1  write enable of the MEM/WB instruction
- memwb_rd  in  REGW  destination of the MEM/WB instruction
- memwb_wdata  in  WIDTH  writeback data
- alu_a, alu_b  out  WIDTH each  ALU operands
- alu_ctl  out  3  ALU control code
- ex_store_data  out  WIDTH  forwarded rt value, for sw
- ex_dest  out  REGW  destination register (rd if reg_dst=1, else rt)
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  control bits passed down the pipe
- load_use_stall  out  1  request to stall IF/ID

Behaviour:
- Register update, on each rising edge, in priority order:
  - rst: all fields load 0.
  - else flush: control bits load 0; data fields don't-care, held at 0.
  - else stall: hold the current contents.
  - else: load all id_* inputs.
- Reset and flush outputs: a registered opcode/funct of 0 decodes to alu_ctl = 010. All ex_* control outputs are 0.
- Flush has priority over stall when both are asserted.
- alu_ctl is combinational from the registered opcode/funct, giving 0-cycle latency into EX:
  - R-type, opcode 000000, by funct:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 111
    - any other funct -> 010
  - Other opcodes:
    - 100011, 101011, 001000 -> 010
    - 000100 -> 110
    - 001100 -> 000
    - 001101 -> 001
    - 001010 -> 111
    - any other opcode -> 010
- Forwarding, evaluated independently for rs and rt:
  - If exmem_reg_write, exmem_rd != 0 and exmem_rd == reg, use exmem_result.
  - Else if memwb_reg_write, memwb_rd != 0 and memwb_rd == reg, use memwb_wdata.
  - Else use the latched register value.
  - EX/MEM takes priority when both stages match.
- Operand selection:
  - alu_a = forwarded rs.
  - alu_b = latched imm if alu_src=1, else forwarded rt.
  - ex_store_data = forwarded rt, always.
- Register 0 is never forwarded; the latched value passes through.
- load_use_stall is combinational: asserted when ex_mem_read=1, ex_dest != 0, and ex_dest equals id_rs or id_rt.
  - The top level drives `stall` for IF/ID from this signal and `flush` for ID/EX from it as well, which inserts a bubble.
- No internal arithmetic; widths pass through unchanged.

Decomposition:
- Shared package mips_pkg holds:
  - ALU control constants: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111.
  - Opcode and funct constants.
- One sub-module, alu_ctl_decode: pure combinational opcode/funct -> alu_ctl. It is reused by the verification model.
- Forwarding comparators stay inline.

Test Plan:
- Reset: hold rst for 2 cycles -> all ex_* outputs are 0, alu_ctl=010, alu_a=0, load_use_stall=0.
- Decode sweep: latch each of the 5 R-type functs and opcodes 100011, 000100, 001100, 001101, 001010 -> alu_ctl = 010, 110, 000, 001, 111, 010, 110, 000, 001, 111.
- Double forward:
  - Setup: rs=3, id_rs_data=5, exmem_rd=3 with exmem_result=0xAAAA, memwb_rd=3 with memwb_wdata=0xBBBB, both write enables set.
  - Expect alu_a=0xAAAA.
  - Drop exmem_reg_write -> alu_a=0xBBBB.
  - Set both rd to 0 -> alu_a=5.
- Immediate path: alu_src=1, imm=0xFFFFFFFC, forwarding rt=7 active -> alu_b=0xFFFFFFFC and ex_store_data = the forwarded value.
- Load-use:
  - Setup: latched lw with rt=8 (reg_dst=0); ID presents id_rs=8.
  - Expect load_use_stall=1.
  - With flush asserted on the next edge -> ex_mem_read=0 and ex_reg_write=0.
  - With id_rs=0 and ex_dest=0 -> load_use_stall=0.
- Stall vs flush:
  - stall=1 for 3 cycles -> outputs held constant.
  - stall=1 and flush=1 together -> bubble loaded.
  - rst asserted mid-stall -> all fields 0 on the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU control codes plus the opcode/funct values
// that the ID/EX stage decodes.
package mips_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctl_decode.sv
// Pure combinational opcode/funct to 3-bit ALU control; unknown codes
// default to add so a zeroed (bubble) instruction is harmless.
module alu_ctl_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_ctl
);

    always_comb begin
        o_alu_ctl = ALU_ADD;
        if (i_opcode == OP_RTYPE) begin
            case (i_funct)
                FN_ADD:  o_alu_ctl = ALU_ADD;
                FN_SUB:  o_alu_ctl = ALU_SUB;
                FN_AND:  o_alu_ctl = ALU_AND;
                FN_OR:   o_alu_ctl = ALU_OR;
                FN_SLT:  o_alu_ctl = ALU_SLT;
                default: o_alu_ctl = ALU_ADD;
            endcase
        end else begin
            case (i_opcode)
                OP_LW, OP_SW, OP_ADDI: o_alu_ctl = ALU_ADD;
                OP_BEQ:                o_alu_ctl = ALU_SUB;
                OP_ANDI:               o_alu_ctl = ALU_AND;
                OP_ORI:                o_alu_ctl = ALU_OR;
                OP_SLTI:               o_alu_ctl = ALU_SLT;
                default:               o_alu_ctl = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register feeding the ripple ALU: latches decoded fields,
// forwards operands from EX/MEM and MEM/WB, and flags load-use hazards.
module id_ex_alu_stage
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_funct,
    input  logic [REGW-1:0]  id_rs,
    input  logic [REGW-1:0]  id_rt,
    input  logic [REGW-1:0]  id_rd,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_reg_dst,
    input  logic             id_alu_src,
    input  logic             exmem_reg_write,
    input  logic [REGW-1:0]  exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [REGW-1:0]  memwb_rd,
    input  logic [WIDTH-1:0] memwb_wdata,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctl,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [REGW-1:0]  ex_dest,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             load_use_stall
);

    logic [5:0]       r_opcode, r_funct;
    logic [REGW-1:0]  r_rs, r_rt, r_rd;
    logic [WIDTH-1:0] r_rs_data, r_rt_data, r_imm;
    logic             r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg;
    logic             r_reg_dst, r_alu_src;

    logic [WIDTH-1:0] w_fwd_rs, w_fwd_rt;
    logic [REGW-1:0]  w_dest;

    // Reset and flush both leave an all-zero bubble (decodes as add, no side effects).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_opcode     <= '0;
            r_funct      <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_alu_src    <= 1'b0;
        end else if (!stall) begin
            r_opcode     <= id_opcode;
            r_funct      <= id_funct;
            r_rs         <= id_rs;
            r_rt         <= id_rt;
            r_rd         <= id_rd;
            r_rs_data    <= id_rs_data;
            r_rt_data    <= id_rt_data;
            r_imm        <= id_imm;
            r_reg_write  <= id_reg_write;
            r_mem_read   <= id_mem_read;
            r_mem_write  <= id_mem_write;
            r_mem_to_reg <= id_mem_to_reg;
            r_reg_dst    <= id_reg_dst;
            r_alu_src    <= id_alu_src;
        end
    end

    alu_ctl_decode u_alu_ctl_decode (
        .i_opcode  (r_opcode),
        .i_funct   (r_funct),
        .o_alu_ctl (alu_ctl)
    );

    // EX/MEM is the younger producer, so it wins over MEM/WB; $0 never forwards.
    always_comb begin
        w_fwd_rs = r_rs_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs))
            w_fwd_rs = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs))
            w_fwd_rs = memwb_wdata;

        w_fwd_rt = r_rt_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rt))
            w_fwd_rt = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rt))
            w_fwd_rt = memwb_wdata;
    end

    assign w_dest         = r_reg_dst ? r_rd : r_rt;
    assign alu_a          = w_fwd_rs;
    assign alu_b          = r_alu_src ? r_imm : w_fwd_rt;
    assign ex_store_data  = w_fwd_rt;
    assign ex_dest        = w_dest;
    assign ex_reg_write   = r_reg_write;
    assign ex_mem_read    = r_mem_read;
    assign ex_mem_write   = r_mem_write;
    assign ex_mem_to_reg  = r_mem_to_reg;

    assign load_use_stall = r_mem_read && (w_dest != '0) &&
                            ((w_dest == id_rs) || (w_dest == id_rt));

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Directed bench for id_ex_alu_stage: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_id_ex_alu_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_dst, id_alu_src;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_wdata;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [2:0]  alu_ctl;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_alu_stage #(.WIDTH(32), .REGW(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .load_use_stall(load_use_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 0; stall = 0; flush = 0;
        id_opcode = 0; id_funct = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        id_mem_to_reg = 0; id_reg_dst = 0; id_alu_src = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_wdata = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        // Non-zero ID inputs so reset has something to override.
        id_opcode = 6'b100011; id_rs = 5'd4; id_rs_data = 32'h1234;
        id_reg_write = 1; id_mem_read = 1; id_mem_write = 1; id_mem_to_reg = 1;
        rst = 1;
        tick(); tick();
        total++;
        if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctl: got %b want 0000",
                {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg});
        end
        total++;
        if (alu_ctl !== 3'b010) begin bad++; $display("FAIL reset_alu_ctl: got %b want 010", alu_ctl); end
        total++;
        if (alu_a !== 32'h0) begin bad++; $display("FAIL reset_alu_a: got %h want 0", alu_a); end
        total++;
        if (load_use_stall !== 1'b0) begin bad++; $display("FAIL reset_lus: got %b want 0", load_use_stall); end
        total++;
        if (ex_dest !== 5'd0) begin bad++; $display("FAIL reset_dest: got %0d want 0", ex_dest); end
        clear_inputs();
    endtask

    task automatic test_decode();
        logic [5:0] ops [14] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                 6'b100011, 6'b000100, 6'b001100, 6'b001101, 6'b001010,
                                 6'b000000, 6'b101011, 6'b001000, 6'b111111};
        logic [5:0] fns [14] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                 6'b100100, 6'b100100, 6'b101010, 6'b100010, 6'b100000,
                                 6'b000111, 6'b101010, 6'b100010, 6'b100010};
        logic [2:0] exp [14] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111,
                                 3'b010, 3'b110, 3'b000, 3'b001, 3'b111,
                                 3'b010, 3'b010, 3'b010, 3'b010};
        clear_inputs();
        for (int i = 0; i < 14; i++) begin
            id_opcode = ops[i]; id_funct = fns[i];
            tick();
            total++;
            if (alu_ctl !== exp[i]) begin
                bad++;
                $display("FAIL decode[%0d] op=%b fn=%b: got %b want %b", i, ops[i], fns[i], alu_ctl, exp[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_double_forward();
        clear_inputs();
        id_rs = 5'd3; id_rs_data = 32'd5;
        tick();
        id_rs = 5'd0; id_rs_data = 32'd0;
        exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'hAAAA;
        memwb_reg_write = 1; memwb_rd = 5'd3; memwb_wdata  = 32'hBBBB;
        #1;
        total++;
        if (alu_a !== 32'hAAAA) begin bad++; $display("FAIL fwd_exmem_prio: got %h want 0000aaaa", alu_a); end
        exmem_reg_write = 0;
        #1;
        total++;
        if (alu_a !== 32'hBBBB) begin bad++; $display("FAIL fwd_memwb: got %h want 0000bbbb", alu_a); end
        exmem_reg_write = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1;
        total++;
        if (alu_a !== 32'd5) begin bad++; $display("FAIL fwd_none: got %h want 00000005", alu_a); end
        clear_inputs();
        // Register 0 latched: even a matching $0 writer must not forward.
        id_rs = 5'd0; id_rs_data = 32'h77;
        tick();
        exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
        #1;
        total++;
        if (alu_a !== 32'h77) begin bad++; $display("FAIL fwd_reg0: got %h want 00000077", alu_a); end
        clear_inputs();
    endtask

    task automatic test_immediate();
        clear_inputs();
        id_rt = 5'd7; id_rt_data = 32'h1; id_alu_src = 1; id_imm = 32'hFFFFFFFC;
        tick();
        exmem_reg_write = 1; exmem_rd = 5'd7; exmem_result = 32'h1234;
        #1;
        total++;
        if (alu_b !== 32'hFFFFFFFC) begin bad++; $display("FAIL imm_alu_b: got %h want fffffffc", alu_b); end
        total++;
        if (ex_store_data !== 32'h1234) begin bad++; $display("FAIL imm_store: got %h want 00001234", ex_store_data); end
        id_alu_src = 0;
        tick();
        total++;
        if (alu_b !== 32'h1234) begin bad++; $display("FAIL reg_alu_b_fwd: got %h want 00001234", alu_b); end
        exmem_reg_write = 0;
        #1;
        total++;
        if (alu_b !== 32'h1) begin bad++; $display("FAIL reg_alu_b: got %h want 00000001", alu_b); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        id_opcode = 6'b100011; id_rs = 5'd2; id_rt = 5'd8; id_rd = 5'd15; id_reg_dst = 0;
        id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
        tick();
        clear_inputs();
        id_rs = 5'd8; id_rt = 5'd1; id_reg_write = 1;
        #1;
        total++;
        if (ex_dest !== 5'd8) begin bad++; $display("FAIL lu_dest: got %0d want 8", ex_dest); end
        total++;
        if (load_use_stall !== 1'b1) begin bad++; $display("FAIL lu_stall_rs: got %b want 1", load_use_stall); end
        flush = 1;
        tick();
        flush = 0;
        total++;
        if ({ex_mem_read, ex_reg_write} !== 2'b00) begin
            bad++; $display("FAIL lu_bubble: got mr=%b rw=%b want 0 0", ex_mem_read, ex_reg_write);
        end
        total++;
        if (load_use_stall !== 1'b0) begin bad++; $display("FAIL lu_after_bubble: got %b want 0", load_use_stall); end
        // Load into $0: no hazard even though ID reads $0.
        clear_inputs();
        id_opcode = 6'b100011; id_rt = 5'd0; id_mem_read = 1;
        tick();
        id_rs = 5'd0; id_rt = 5'd0; id_mem_read = 0;
        #1;
        total++;
        if (load_use_stall !== 1'b0) begin bad++; $display("FAIL lu_reg0: got %b want 0", load_use_stall); end
        // Hazard through the rt read port.
        clear_inputs();
        id_opcode = 6'b100011; id_rt = 5'd9; id_mem_read = 1;
        tick();
        id_mem_read = 0; id_rs = 5'd1; id_rt = 5'd9;
        #1;
        total++;
        if (load_use_stall !== 1'b1) begin bad++; $display("FAIL lu_stall_rt: got %b want 1", load_use_stall); end
        clear_inputs();
        tick();
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        id_opcode = 6'b000000; id_funct = 6'b100010;
        id_rs = 5'd2; id_rs_data = 32'h11; id_rt = 5'd4; id_rt_data = 32'h22;
        id_rd = 5'd6; id_reg_dst = 1; id_reg_write = 1;
        tick();
        // Different instruction waiting in ID while EX holds.
        id_opcode = 6'b001101; id_rs_data = 32'h99; id_rd = 5'd12; id_reg_write = 0;
        stall = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (alu_a !== 32'h11 || ex_dest !== 5'd6 || ex_reg_write !== 1'b1 || alu_ctl !== 3'b110) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got a=%h dest=%0d rw=%b ctl=%b want a=00000011 dest=6 rw=1 ctl=110",
                         c, alu_a, ex_dest, ex_reg_write, alu_ctl);
            end
        end
        flush = 1;
        tick();
        flush = 0;
        total++;
        if (ex_reg_write !== 1'b0 || alu_a !== 32'h0 || alu_ctl !== 3'b010) begin
            bad++;
            $display("FAIL stall_flush: got rw=%b a=%h ctl=%b want rw=0 a=0 ctl=010", ex_reg_write, alu_a, alu_ctl);
        end
        // Reload, then reset while stalled.
        id_opcode = 6'b100011; id_rs_data = 32'h55; id_rt = 5'd3; id_reg_dst = 0;
        id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1; stall = 0;
        tick();
        total++;
        if (ex_mem_read !== 1'b1 || alu_a !== 32'h55) begin
            bad++; $display("FAIL reload: got mr=%b a=%h want mr=1 a=00000055", ex_mem_read, alu_a);
        end
        stall = 1;
        tick();
        rst = 1;
        tick();
        rst = 0;
        total++;
        if ({ex_reg_write, ex_mem_read, ex_mem_to_reg} !== 3'b000 || alu_a !== 32'h0 || ex_dest !== 5'd0) begin
            bad++;
            $display("FAIL rst_mid_stall: got ctl=%b a=%h dest=%0d want 000 0 0",
                     {ex_reg_write, ex_mem_read, ex_mem_to_reg}, alu_a, ex_dest);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_decode();
        test_double_forward();
        test_immediate();
        test_load_use();
        test_stall_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
